maze_path_checker: RTL and testbench
====================================

Name: maze_path_checker

Overview:
- Consumer end of the maze solver's move stream: replays a move list from the result list and walks it from start cell (0,0) over the maze wall memory.
- Accepts one 2-bit move per handshake, bounds-checks and wall-checks each step, and tracks position and step count.
- Issues a pass/fail verdict when the last move is consumed.
- Sits between the result-list reader (move producer) and the maze wall RAM (synchronous read port shared with the solver; the solver is idle while the checker runs).

Parameters:
- N, 4, coordinate width; maze is 2^N x 2^N; goal cell is X = Y = all ones.
- STEP_W, 8, width of step counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin a check; sampled in IDLE or DONE only.
- move_valid  in  1  producer has a move on move_data.
- move_data  in  2  direction: 00 = Y-1, 01 = X+1, 10 = X-1, 11 = Y+1 (same encoding as solver counter).
- move_last  in  1  qualifies move_data as final move of the path.
- move_ready  out  1  checker accepts a move this cycle.
- maze_rd  out  1  wall-RAM read strobe.
- maze_x  out  N  read address X.
- maze_y  out  N  read address Y.
- maze_wall  in  1  wall bit, valid the cycle after maze_rd (1 = blocked).
- pos_x  out  N  current X.
- pos_y  out  N  current Y.
- step_count  out  STEP_W  moves committed since start.
- busy  out  1  check in progress.
- done  out  1  verdict valid; held until next start.
- pass  out  1  path legal and ends on goal; meaningful when done = 1.
- err_code  out  2  00 none, 01 out of bounds, 10 wall hit, 11 last move not on goal.

Behaviour:
- Reset (rst = 0 at a clock edge, any state including mid-check):
  - state <= IDLE.
  - pos_x, pos_y, step_count, err_code <= 0.
  - busy, done, pass, move_ready, maze_rd <= 0.
- States: IDLE, RECV, MEM, DONE.
- IDLE:
  - On start: pos <= (0,0), step_count <= 0, done/pass/err_code cleared, busy <= 1, go to RECV.
- RECV:
  - move_ready = 1 (combinational, state-decoded).
  - On move_valid & move_ready, compute next cell with N-bit arithmetic:
    - Decrementing from 0 or incrementing from all ones is out of bounds: err_code <= 01, go to DONE; pos is unchanged.
    - Otherwise latch next cell and move_last, drive maze_rd = 1 with maze_x/maze_y = next cell in that same cycle, go to MEM.
  - move_valid = 0: remain in RECV.
- MEM:
  - move_ready = 0.
  - maze_wall = 1: err_code <= 10, go to DONE; pos is unchanged.
  - Else:
    - pos <= next cell.
    - step_count += 1, saturating at all ones with no error.
    - If the latched last flag is set: next cell == goal gives pass <= 1, err_code <= 00; otherwise err_code <= 11. Go to DONE.
    - If the last flag is clear: return to RECV.
- DONE:
  - done = 1, busy = 0, move_ready = 0.
  - All outputs held.
  - start re-initialises exactly as from IDLE.
- start while in RECV or MEM is ignored.
- Passing through the goal before the last move is not an error; only the final position is judged.
- Start cell (0,0) is never wall-checked.
- Throughput: one move per 2 cycles minimum.
- Verdict latency: done rises 2 cycles after the last move handshake, or 1 cycle after an out-of-bounds handshake.
- maze_x/maze_y hold the last issued address when maze_rd = 0.

Test Plan:
- Empty maze, N=4, start, then 15 x 01 followed by 15 x 11 (last on final move), move_valid held high -> move_ready toggles every other cycle; done = 1, pass = 1, err_code = 00, pos = (15,15), step_count = 30.
- First move 00 at (0,0) -> done 1 cycle after handshake; err_code = 01, pass = 0, pos = (0,0), step_count = 0, maze_rd never asserted.
- Wall at (1,0), move 01 -> maze_rd with maze_x = 1, maze_y = 0; next cycle err_code = 10, pos = (0,0), step_count = 0.
- Empty maze, moves 01, 11 with last on second -> err_code = 11, pass = 0, pos = (1,1), step_count = 2.
- Producer stalls move_valid low for 5 cycles mid-path -> checker waits in RECV with move_ready = 1; result identical to the unstalled run.
- rst = 0 while in MEM after 3 moves -> next cycle busy = 0, done = 0, pos = (0,0), step_count = 0; a fresh start then runs normally.

Source files
------------

// File: rtl/maze_path_checker.sv
// maze_path_checker: replays a solver move list from cell (0,0), checking each
// step against the maze bounds and the wall RAM, and issues a pass/fail verdict
// once the move flagged as last has been consumed.
module maze_path_checker #(
    parameter int N      = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              move_valid,
    input  logic [1:0]        move_data,
    input  logic              move_last,
    output logic              move_ready,
    output logic              maze_rd,
    output logic [N-1:0]      maze_x,
    output logic [N-1:0]      maze_y,
    input  logic              maze_wall,
    output logic [N-1:0]      pos_x,
    output logic [N-1:0]      pos_y,
    output logic [STEP_W-1:0] step_count,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_MEM  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_BOUNDS = 2'b01,
        ERR_WALL   = 2'b10,
        ERR_GOAL   = 2'b11
    } err_t;

    // Move encoding shared with the solver's direction counter.
    localparam logic [1:0] MOVE_YDEC = 2'b00;
    localparam logic [1:0] MOVE_XINC = 2'b01;
    localparam logic [1:0] MOVE_XDEC = 2'b10;
    localparam logic [1:0] MOVE_YINC = 2'b11;

    localparam logic [N-1:0]      COORD_ZERO = '0;
    localparam logic [N-1:0]      COORD_MAX  = '1;
    localparam logic [N-1:0]      COORD_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] STEP_MAX   = '1;
    localparam logic [STEP_W-1:0] STEP_ONE   = {{(STEP_W-1){1'b0}}, 1'b1};

    state_t      state;
    err_t        err_q;
    logic [N-1:0] cell_x;      // cell being wall-checked; also the held RAM address
    logic [N-1:0] cell_y;
    logic         last_q;      // the move in flight was flagged as the final one

    logic [N-1:0] next_x;
    logic [N-1:0] next_y;
    logic         out_of_bounds;
    logic         accept;

    assign move_ready = (state == S_RECV);
    assign accept     = move_valid & move_ready;
    assign maze_rd    = accept & ~out_of_bounds;
    // The RAM address follows the candidate cell while reading, else holds.
    assign maze_x     = maze_rd ? next_x : cell_x;
    assign maze_y     = maze_rd ? next_y : cell_y;
    assign err_code   = err_q;

    // Candidate cell for the offered move, with the edge-of-maze check.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        next_x        = pos_x;
        next_y        = pos_y;
        out_of_bounds = 1'b0;
        case (move_data)
            MOVE_YDEC: begin
                if (pos_y == COORD_ZERO) out_of_bounds = 1'b1;
                else                     next_y = pos_y - COORD_ONE;
            end
            MOVE_XINC: begin
                if (pos_x == COORD_MAX) out_of_bounds = 1'b1;
                else                    next_x = pos_x + COORD_ONE;
            end
            MOVE_XDEC: begin
                if (pos_x == COORD_ZERO) out_of_bounds = 1'b1;
                else                     next_x = pos_x - COORD_ONE;
            end
            MOVE_YINC: begin
                if (pos_y == COORD_MAX) out_of_bounds = 1'b1;
                else                    next_y = pos_y + COORD_ONE;
            end
            default: out_of_bounds = 1'b0;
        endcase
    end

    // Check sequencer: accept a move, read its wall bit, commit or stop.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples the pre-edge values of the others.
        if (!rst) begin
            state      <= S_IDLE;
            err_q      <= ERR_NONE;
            pos_x      <= '0;
            pos_y      <= '0;
            step_count <= '0;
            cell_x     <= '0;
            cell_y     <= '0;
            last_q     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pos_x      <= '0;
                        pos_y      <= '0;
                        step_count <= '0;
                        err_q      <= ERR_NONE;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        state      <= S_RECV;
                    end
                end

                S_RECV: begin
                    if (accept) begin
                        if (out_of_bounds) begin
                            err_q <= ERR_BOUNDS;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            cell_x <= next_x;
                            cell_y <= next_y;
                            last_q <= move_last;
                            state  <= S_MEM;
                        end
                    end
                end

                S_MEM: begin
                    if (maze_wall) begin
                        err_q <= ERR_WALL;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        pos_x <= cell_x;
                        pos_y <= cell_y;
                        if (step_count != STEP_MAX) step_count <= step_count + STEP_ONE;
                        if (last_q) begin
                            // Only the final cell is judged; passing the goal earlier is fine.
                            if (cell_x == COORD_MAX && cell_y == COORD_MAX) begin
                                pass  <= 1'b1;
                                err_q <= ERR_NONE;
                            end else begin
                                err_q <= ERR_GOAL;
                            end
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_RECV;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_path_checker.sv
// tb_maze_path_checker: directed and randomized move lists walked against an
// integer-coordinate reference model of the maze rules.
module tb_maze_path_checker;

    localparam int N      = 4;
    localparam int STEP_W = 8;
    localparam int MAXC   = (1 << N) - 1;
    localparam int SMAX   = (1 << STEP_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              move_valid = 1'b0;
    logic [1:0]        move_data = 2'b00;
    logic              move_last = 1'b0;
    logic              move_ready;
    logic              maze_rd;
    logic [N-1:0]      maze_x;
    logic [N-1:0]      maze_y;
    logic              maze_wall = 1'b0;
    logic [N-1:0]      pos_x;
    logic [N-1:0]      pos_y;
    logic [STEP_W-1:0] step_count;
    logic              busy;
    logic              done;
    logic              pass;
    logic [1:0]        err_code;

    int n_tests = 0;
    int n_fail  = 0;

    bit wall [0:MAXC][0:MAXC];
    int mv [0:1023];
    int n_mv = 0;

    // Expected held RAM address, valid once a read has been issued since reset.
    bit addr_seen = 1'b0;
    int exp_ax = 0;
    int exp_ay = 0;

    maze_path_checker #(.N(N), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .move_valid (move_valid),
        .move_data  (move_data),
        .move_last  (move_last),
        .move_ready (move_ready),
        .maze_rd    (maze_rd),
        .maze_x     (maze_x),
        .maze_y     (maze_y),
        .maze_wall  (maze_wall),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .step_count (step_count),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // Synchronous-read wall RAM: bit appears the cycle after the strobe.
    always @(posedge clk) begin
        if (maze_rd === 1'b1) maze_wall <= wall[maze_x][maze_y];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void clear_maze();
        for (int x = 0; x <= MAXC; x++)
            for (int y = 0; y <= MAXC; y++)
                wall[x][y] = 1'b0;
    endfunction

    function automatic void random_maze(input int pct);
        for (int x = 0; x <= MAXC; x++)
            for (int y = 0; y <= MAXC; y++)
                wall[x][y] = ($urandom_range(99) < pct);
    endfunction

    function automatic void add_moves(input int d, input int count);
        for (int k = 0; k < count; k++) begin
            mv[n_mv] = d;
            n_mv++;
        end
    endfunction

    // Direction rules: 0 = Y-1, 1 = X+1, 2 = X-1, 3 = Y+1.
    function automatic void step_of(input int d, input int x, input int y,
                                    output int nx, output int ny);
        nx = x;
        ny = y;
        case (d)
            0:       ny = y - 1;
            1:       nx = x + 1;
            2:       nx = x - 1;
            default: ny = y + 1;
        endcase
    endfunction

    // Reference verdict for the whole move list in mv[0:n_mv-1].
    function automatic void ref_walk(output int fx, output int fy, output int steps,
                                     output int err, output int ps, output int acc);
        int x = 0;
        int y = 0;
        int nx;
        int ny;
        bit stop = 1'b0;
        steps = 0;
        err   = 0;
        ps    = 0;
        acc   = 0;
        for (int k = 0; k < n_mv && !stop; k++) begin
            acc++;
            step_of(mv[k], x, y, nx, ny);
            if (nx < 0 || nx > MAXC || ny < 0 || ny > MAXC) begin
                err  = 1;
                stop = 1'b1;
            end else if (wall[nx][ny]) begin
                err  = 2;
                stop = 1'b1;
            end else begin
                x = nx;
                y = ny;
                if (steps < SMAX) steps++;
                if (k == n_mv - 1) begin
                    if (x == MAXC && y == MAXC) ps = 1;
                    else                        err = 3;
                end
            end
        end
        fx = x;
        fy = y;
    endfunction

    // Start a check, stream mv[] with optional stall / mid-check reset, judge the verdict.
    task automatic run_path(input string name, input int stall_at, input int stall_len,
                            input int abort_after);
        int e_x, e_y, e_steps, e_err, e_pass, e_acc;
        int i, hs, cyc, first_hs, last_hs;
        int px, py, nx, ny;
        bit inb, stalled, finished;
        logic [N-1:0] hold_x, hold_y;

        ref_walk(e_x, e_y, e_steps, e_err, e_pass, e_acc);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, ":busy_after_start"}, busy, 1);
        check({name, ":done_after_start"}, done, 0);
        check({name, ":step_after_start"}, step_count, 0);

        px = 0; py = 0; i = 0; hs = 0; cyc = 0; first_hs = 0; last_hs = 0;
        stalled = 1'b0; finished = 1'b0;

        while (!finished && cyc < 4000) begin
            if (abort_after > 0 && hs == abort_after) begin
                check({name, ":abort_in_mem_ready"}, move_ready, 0);
                check({name, ":abort_in_mem_busy"}, busy, 1);
                rst = 1'b0;
                move_valid = 1'b0;
                @(negedge clk);
                check({name, ":rst_busy"}, busy, 0);
                check({name, ":rst_done"}, done, 0);
                check({name, ":rst_pos"}, {pos_x, pos_y}, 0);
                check({name, ":rst_step"}, step_count, 0);
                check({name, ":rst_err"}, err_code, 0);
                check({name, ":rst_ready"}, move_ready, 0);
                rst = 1'b1;
                addr_seen = 1'b0;
                return;
            end else if (done === 1'b1) begin
                finished = 1'b1;
            end else begin
                if (i < n_mv) begin
                    if (i == stall_at && !stalled && stall_len > 0 && move_ready === 1'b1) begin
                        stalled = 1'b1;
                        move_valid = 1'b0;
                        repeat (stall_len) begin
                            @(negedge clk);
                            cyc++;
                            check({name, ":stall_ready"}, move_ready, 1);
                        end
                    end
                    move_valid = 1'b1;
                    move_data  = 2'(mv[i]);
                    move_last  = (i == n_mv - 1);
                end else begin
                    move_valid = 1'b0;
                    move_last  = 1'b0;
                end
                #1;
                if (move_valid && move_ready === 1'b1) begin
                    step_of(mv[i], px, py, nx, ny);
                    inb = (nx >= 0 && nx <= MAXC && ny >= 0 && ny <= MAXC);
                    check({name, ":maze_rd_on_move"}, maze_rd, inb);
                    if (inb) begin
                        check({name, ":maze_x"}, maze_x, nx);
                        check({name, ":maze_y"}, maze_y, ny);
                        exp_ax = nx;
                        exp_ay = ny;
                        addr_seen = 1'b1;
                        if (!wall[nx][ny]) begin
                            px = nx;
                            py = ny;
                        end
                    end
                    if (hs == 0) first_hs = cyc;
                    last_hs = cyc;
                    hs++;
                    i++;
                end else begin
                    check({name, ":maze_rd_idle"}, maze_rd, 0);
                    if (addr_seen) begin
                        check({name, ":maze_x_hold"}, maze_x, exp_ax);
                        check({name, ":maze_y_hold"}, maze_y, exp_ay);
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        move_valid = 1'b0;
        move_last  = 1'b0;

        check({name, ":done"}, done, 1);
        check({name, ":busy"}, busy, 0);
        check({name, ":ready_in_done"}, move_ready, 0);
        check({name, ":pass"}, pass, e_pass);
        check({name, ":err_code"}, err_code, e_err);
        check({name, ":pos_x"}, pos_x, e_x);
        check({name, ":pos_y"}, pos_y, e_y);
        check({name, ":step_count"}, step_count, e_steps);
        check({name, ":accepted"}, hs, e_acc);
        check({name, ":verdict_latency"}, cyc - last_hs, (e_err == 1) ? 1 : 2);
        if (stall_len == 0)
            check({name, ":throughput"}, last_hs - first_hs, 2 * (hs - 1));

        hold_x = pos_x;
        hold_y = pos_y;
        repeat (3) @(negedge clk);
        check({name, ":done_held"}, done, 1);
        check({name, ":pos_held"}, {pos_x, pos_y}, {hold_x, hold_y});
    endtask

    // Random monotone route to the goal: 15 X+1 and 15 Y+1 in random order.
    function automatic void monotone_path();
        int a = MAXC;
        int b = MAXC;
        n_mv = 0;
        while (a + b > 0) begin
            if (b == 0 || (a > 0 && $urandom_range(1) == 0)) begin
                add_moves(1, 1);
                a--;
            end else begin
                add_moves(3, 1);
                b--;
            end
        end
    endfunction

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset:busy", busy, 0);
        check("reset:done", done, 0);
        check("reset:pass", pass, 0);
        check("reset:err", err_code, 0);
        check("reset:pos", {pos_x, pos_y}, 0);
        check("reset:step", step_count, 0);
        check("reset:ready", move_ready, 0);
        check("reset:maze_rd", maze_rd, 0);
        rst = 1'b1;
        @(negedge clk);

        // Straight route along the bottom then up the right edge
        clear_maze();
        n_mv = 0;
        add_moves(1, MAXC);
        add_moves(3, MAXC);
        run_path("straight", -1, 0, 0);

        // Immediate out-of-bounds move
        n_mv = 0;
        add_moves(0, 1);
        run_path("oob_first", -1, 0, 0);

        // Wall directly to the right of the start cell
        clear_maze();
        wall[1][0] = 1'b1;
        n_mv = 0;
        add_moves(1, 1);
        run_path("wall_first", -1, 0, 0);

        // Legal path that stops short of the goal
        clear_maze();
        n_mv = 0;
        add_moves(1, 1);
        add_moves(3, 1);
        run_path("not_goal", -1, 0, 0);

        // Same straight route with a 5-cycle producer stall
        n_mv = 0;
        add_moves(1, MAXC);
        add_moves(3, MAXC);
        run_path("stalled", 7, 5, 0);

        // Reset while a wall read is in flight, then a clean rerun
        n_mv = 0;
        add_moves(1, 10);
        run_path("abort", -1, 0, 3);
        n_mv = 0;
        add_moves(1, MAXC);
        add_moves(3, MAXC);
        run_path("after_abort", -1, 0, 0);

        // Step counter saturation on a long back-and-forth path
        n_mv = 0;
        for (int k = 0; k < 150; k++) begin
            add_moves(1, 1);
            add_moves(2, 1);
        end
        run_path("saturate", -1, 0, 0);

        // Pass through the goal, step off, and come back on the last move
        n_mv = 0;
        add_moves(1, MAXC);
        add_moves(3, MAXC);
        add_moves(2, 1);
        add_moves(1, 1);
        run_path("revisit_goal", -1, 0, 0);

        // Out of bounds at the far edge
        n_mv = 0;
        add_moves(1, MAXC + 1);
        run_path("oob_far", -1, 0, 0);

        // Randomized mazes and paths
        for (int t = 0; t < 24; t++) begin
            if (t % 3 == 0) clear_maze();
            else            random_maze(15);
            if (t % 2 == 0) begin
                monotone_path();
            end else begin
                n_mv = 0;
                for (int k = 0, len = 1 + $urandom_range(39); k < len; k++)
                    add_moves(($urandom_range(9) < 7) ? (($urandom_range(1) == 0) ? 1 : 3)
                                                      : (($urandom_range(1) == 0) ? 0 : 2), 1);
            end
            run_path($sformatf("rand%0d", t), $urandom_range(n_mv), $urandom_range(3), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
